// File: rtl/matrix_stream_pkg.sv
// rtl/matrix_stream_pkg.sv - shared types and constants for the matrix stream generator
package matrix_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HEADER,
        PAYLOAD,
        GAP
    } state_e;

    localparam logic [7:0]  HDR_MAGIC  = 8'hFF;
    localparam logic [1:0]  MODE_CONST = 2'd0;
    localparam logic [1:0]  MODE_INCR  = 2'd1;
    localparam logic [1:0]  MODE_LFSR  = 2'd2;
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] w);
        return w[0] ? ((w >> 1) ^ LFSR_TAPS) : (w >> 1);
    endfunction

    // An all-zero LFSR state would lock up, so seed 0 starts from 1
    function automatic logic [31:0] first_word(input logic [31:0] seed, input logic [1:0] mode);
        return (mode == MODE_LFSR && seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - payload pattern source; word_o is always the next beat to send
module stream_pattern_gen
    import matrix_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        restart_i,
    input  logic        advance_i,
    input  logic [31:0] seed_i,
    input  logic [1:0]  mode_i,
    output logic [31:0] word_o
);

    logic [31:0] seed_q, seed_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  mode_q, mode_d;

    always_comb begin
        seed_d = seed_q;
        mode_d = mode_q;
        word_d = word_q;
        if (load_i) begin
            seed_d = seed_i;
            mode_d = (mode_i == MODE_INCR || mode_i == MODE_LFSR) ? mode_i : MODE_CONST;
            word_d = first_word(seed_i, mode_d);
        end else if (restart_i) begin
            word_d = first_word(seed_q, mode_q);
        end else if (advance_i) begin
            case (mode_q)
                MODE_INCR: word_d = word_q + 32'd1;
                MODE_LFSR: word_d = lfsr_step(word_q);
                default:   word_d = word_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q <= '0;
            mode_q <= MODE_CONST;
            word_q <= '0;
        end else begin
            seed_q <= seed_d;
            mode_q <= mode_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/matrix_stream_generator.sv
// rtl/matrix_stream_generator.sv - run-time configured framed AXI4-Stream stimulus source
module matrix_stream_generator
    import matrix_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int FRM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [FRM_W-1:0]  cfg_frames,
    input  logic [LEN_W-1:0]  cfg_delay,
    input  logic [LEN_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_mode,
    input  logic [31:0]       cfg_seed,
    output logic [DATA_W-1:0] out_TDATA,
    output logic              out_TVALID,
    output logic              out_TLAST,
    input  logic              out_TREADY,
    output logic              busy,
    output logic              done
);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q, delay_q, gap_q, cnt_q;
    logic [FRM_W-1:0]   frames_q, frm_q;
    logic [DATA_W-1:0]  tdata_q;
    logic               tvalid_q, tlast_q, busy_q, done_q;

    logic               hs, last_frame;
    logic [LEN_W-1:0]   cnt_inc, beat_nxt, len_m1;
    logic [31:0]        pat_word;

    function automatic logic [DATA_W-1:0] hdr_of(input logic [LEN_W-1:0] l);
        return DATA_W'({HDR_MAGIC, 8'h00, 16'(l)});
    endfunction

    assign hs         = tvalid_q & out_TREADY;
    assign last_frame = (frm_q == frames_q - 1'b1);
    assign cnt_inc    = cnt_q + 1'b1;
    assign len_m1     = len_q - 1'b1;
    assign beat_nxt   = (state_q == HEADER) ? '0 : cnt_inc;

    stream_pattern_gen u_pattern (
        .clk       (clk),
        .reset     (reset),
        .load_i    ((state_q == IDLE) & start),
        .restart_i (hs & tlast_q),
        .advance_i (hs & ~tlast_q),
        .seed_i    (cfg_seed),
        .mode_i    (cfg_mode),
        .word_o    (pat_word)
    );

    // Outputs only change when no beat is pending or the pending beat is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            delay_q  <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            frames_q <= '0;
            frm_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    len_q    <= cfg_len;
                    frames_q <= (cfg_frames == '0) ? {{(FRM_W-1){1'b0}}, 1'b1} : cfg_frames;
                    delay_q  <= cfg_delay;
                    gap_q    <= cfg_gap;
                    cnt_q    <= '0;
                    frm_q    <= '0;
                    busy_q   <= 1'b1;
                    if (cfg_delay == '0) begin
                        state_q  <= HEADER;
                        tvalid_q <= 1'b1;
                        tdata_q  <= hdr_of(cfg_len);
                        tlast_q  <= (cfg_len == '0);
                    end else begin
                        state_q <= DELAY;
                    end
                end
                DELAY: if (out_TREADY) begin
                    if (cnt_inc == delay_q) begin
                        cnt_q    <= '0;
                        state_q  <= HEADER;
                        tvalid_q <= 1'b1;
                        tdata_q  <= hdr_of(len_q);
                        tlast_q  <= (len_q == '0);
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HEADER, PAYLOAD: if (out_TREADY) begin
                    if (tlast_q) begin
                        cnt_q <= '0;
                        if (last_frame) begin
                            state_q  <= IDLE;
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            frm_q <= frm_q + 1'b1;
                            if (gap_q == '0) begin
                                state_q <= HEADER;
                                tdata_q <= hdr_of(len_q);
                                tlast_q <= (len_q == '0);
                            end else begin
                                state_q  <= GAP;
                                tvalid_q <= 1'b0;
                                tdata_q  <= '0;
                                tlast_q  <= 1'b0;
                            end
                        end
                    end else begin
                        state_q <= PAYLOAD;
                        cnt_q   <= beat_nxt;
                        tdata_q <= DATA_W'(pat_word);
                        tlast_q <= (beat_nxt == len_m1);
                    end
                end
                GAP: begin
                    if (cnt_inc == gap_q) begin
                        cnt_q    <= '0;
                        state_q  <= HEADER;
                        tvalid_q <= 1'b1;
                        tdata_q  <= hdr_of(len_q);
                        tlast_q  <= (len_q == '0);
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_TDATA  = tdata_q;
    assign out_TVALID = tvalid_q;
    assign out_TLAST  = tlast_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
